qft_rotation_scheduler: RTL

//  Upstream sequencer for controlled_phase_rotation in the QFT datapath. Holds one complex amplitude per qubit.
//  On start, walks the QFT controlled-rotation schedule. For each (target j, control k>j) pair it:
//   - issues one rotation with theta = pi/2^(k-j);
//   - writes the result back into amplitude j.

---
 rtl/qft_pkg.sv | 23 ++
 rtl/qft_amp_regfile.sv | 66 ++++++
 rtl/qft_rotation_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/qft_pkg.sv
// Shared constants and state encoding for the QFT rotation scheduler.
package qft_pkg;

   // Q2.14 fixed-point constants (16'h4000 = 1.0)
   localparam logic [15:0] ONE           = 16'h4000;
   localparam logic [15:0] THETA_HALF_PI = 16'h6487;
   localparam logic [15:0] THETA_PI      = 16'hC90F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_NEXT,
      ST_FINISH
   } state_t;

   // Slot index width; a single-slot file still needs one address bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/qft_amp_regfile.sv
// Amplitude register file: one write port, two async operand reads,
// one registered readback port. Every slot clears on reset.
module qft_amp_regfile
   import qft_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata_real,
   input  logic [WIDTH-1:0] wdata_imag,
   input  logic [AW-1:0]    ra_addr,
   output logic [WIDTH-1:0] ra_real,
   output logic [WIDTH-1:0] ra_imag,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] rb_real,
   output logic [WIDTH-1:0] rb_imag,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_real,
   output logic [WIDTH-1:0] rd_imag
);

   // Depth is rounded up to the full address space so any index is legal;
   // slots at or above N are held at zero.
   localparam int DEPTH = 2 ** AW;

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0]   rd_real_q;
   logic [WIDTH-1:0]   rd_imag_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam bit USED = (gi < N);
      // Per-slot storage: cleared on reset, written when addressed
      always_ff @(posedge clk) begin
         if (rst || !USED) begin
            mem_q[gi] <= '0;
         end else if (we && (waddr == AW'(gi))) begin
            mem_q[gi] <= {wdata_real, wdata_imag};
         end
      end
   end

   assign ra_real = mem_q[ra_addr][2*WIDTH-1:WIDTH];
   assign ra_imag = mem_q[ra_addr][WIDTH-1:0];
   assign rb_real = mem_q[rb_addr][2*WIDTH-1:WIDTH];
   assign rb_imag = mem_q[rb_addr][WIDTH-1:0];

   // Registered readback, one cycle after rd_addr is presented
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_real_q <= '0;
         rd_imag_q <= '0;
      end else begin
         rd_real_q <= mem_q[rd_addr][2*WIDTH-1:WIDTH];
         rd_imag_q <= mem_q[rd_addr][WIDTH-1:0];
      end
   end

   assign rd_real = rd_real_q;
   assign rd_imag = rd_imag_q;

endmodule

// File: rtl/qft_rotation_scheduler.sv
// Walks the QFT controlled-rotation schedule over the amplitude file,
// issuing one rotation per (target j, control k>j) pair and writing the
// result back into amplitude j.
module qft_rotation_scheduler
   import qft_pkg::*;
#(
   parameter int  WIDTH          = 16,
   parameter int  N_QUBITS       = 4,
   parameter int  TIMEOUT_CYCLES = 256,
   localparam int AW             = addr_width(N_QUBITS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             load_we,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_real,
   input  logic [WIDTH-1:0] load_imag,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_real,
   output logic [WIDTH-1:0] rd_imag,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             rot_start,
   output logic [WIDTH-1:0] rot_control_real,
   output logic [WIDTH-1:0] rot_control_imag,
   output logic [WIDTH-1:0] rot_target_real,
   output logic [WIDTH-1:0] rot_target_imag,
   output logic [WIDTH-1:0] rot_theta,
   input  logic [WIDTH-1:0] rot_out_real,
   input  logic [WIDTH-1:0] rot_out_imag,
   input  logic             rot_done
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    j_q, j_d;
   logic [AW-1:0]    k_q, k_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] res_real_q, res_real_d;
   logic [WIDTH-1:0] res_imag_q, res_imag_d;
   logic             rot_done_q;
   logic             rot_done_rise;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_real;
   logic [WIDTH-1:0] wr_imag;
   logic [AW-1:0]    theta_shift;

   // A level left high by the previous rotation must not complete the next one
   assign rot_done_rise = rot_done && !rot_done_q;

   // State, loop counters, timer, error flag and captured result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         j_q        <= '0;
         k_q        <= '0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         res_real_q <= '0;
         res_imag_q <= '0;
         rot_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         j_q        <= j_d;
         k_q        <= k_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         res_real_q <= res_real_d;
         res_imag_q <= res_imag_d;
         rot_done_q <= rot_done;
      end
   end

   // Next-state logic; the timer holds cycles elapsed since rot_start
   always_comb begin
      state_d    = state_q;
      j_d        = j_q;
      k_d        = k_q;
      timer_d    = timer_q;
      err_d      = err_q;
      res_real_d = res_real_q;
      res_imag_d = res_imag_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               j_d     = '0;
               k_d     = AW'(1);
               state_d = (N_QUBITS == 1) ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = TW'(1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (rot_done_rise) begin
               res_real_d = rot_out_real;
               res_imag_d = rot_out_imag;
               state_d    = ST_WRITE;
            end else if (timer_q >= TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_WRITE: begin
            state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (k_q < AW'(N_QUBITS - 1)) begin
               k_d     = k_q + AW'(1);
               state_d = ST_ISSUE;
            end else if (j_q < AW'(N_QUBITS - 2)) begin
               j_d     = j_q + AW'(1);
               k_d     = j_q + AW'(2);
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Single write port: write-back in WRITE, otherwise host load while idle
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = load_addr;
      wr_real = load_real;
      wr_imag = load_imag;
      if (state_q == ST_WRITE) begin
         wr_en   = 1'b1;
         wr_addr = j_q;
         wr_real = res_real_q;
         wr_imag = res_imag_q;
      end else if ((state_q == ST_IDLE) && load_we) begin
         wr_en = 1'b1;
      end
   end

   qft_amp_regfile #(
      .WIDTH (WIDTH),
      .N     (N_QUBITS),
      .AW    (AW)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .we         (wr_en),
      .waddr      (wr_addr),
      .wdata_real (wr_real),
      .wdata_imag (wr_imag),
      .ra_addr    (k_q),
      .ra_real    (rot_control_real),
      .ra_imag    (rot_control_imag),
      .rb_addr    (j_q),
      .rb_real    (rot_target_real),
      .rb_imag    (rot_target_imag),
      .rd_addr    (rd_addr),
      .rd_real    (rd_real),
      .rd_imag    (rd_imag)
   );

   // Operands come straight from amp[j]/amp[k]; nothing writes those slots
   // between ISSUE and the end of WAIT, so they stay stable for the rotation.
   assign theta_shift = k_q - j_q - AW'(1);
   assign rot_theta   = (k_q > j_q) ? (WIDTH'(THETA_HALF_PI) >> theta_shift) : '0;

   assign rot_start = (state_q == ST_ISSUE);
   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                      (state_q == ST_WRITE) || (state_q == ST_NEXT);
   assign done      = (state_q == ST_FINISH);
   assign err       = err_q;

endmodule
